adc_scan_ctrl: RTL and testbench
================================

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: ADC channels scanned, legal 1..8.
REQ-002 Parameter ADC_W, default 8: ADC sample width, legal 4..12.
REQ-003 Parameter PERIOD, default 1_000_000: clk cycles from one auto-scan start to the next, legal ≥ 16.
REQ-004 Parameter TIMEOUT, default 4096: max clk cycles to wait for spi_done.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse; requests one scan of all channels.
REQ-008 auto_en  in  1  level; high = periodic scanning every PERIOD cycles.
REQ-009 spi_start  out  1  single-cycle conversion request to the SPI master.
REQ-010 spi_ch  out  3  channel index for the current conversion.
REQ-011 spi_done  in  1  single-cycle pulse; spi_data valid in the same cycle.
REQ-012 spi_data  in  ADC_W  conversion result.
REQ-013 tx_data  out  8  ASCII byte to the UART transmitter.
REQ-014 tx_load  out  1  single-cycle byte strobe.
REQ-015 tx_busy  in  1  UART busy; high from the cycle after tx_load until the byte is sent.
REQ-016 disp_sel  in  3  channel shown on disp_data.
REQ-017 disp_data  out  ADC_W  last stored sample of channel disp_sel (combinational read).
REQ-018 scan_busy  out  1  high from scan start until the last byte is loaded.
REQ-019 err_timeout, err_overrun  out  1 each  sticky error flags.

Function
REQ-020 FSM states: IDLE, CONV, WAITC, SEND, NEXT; reset state IDLE.
REQ-021 IDLE→CONV on a start pulse, or on period tick while auto_en=1; channel index is set to 0.
REQ-022 CONV: spi_start=1 for exactly one cycle with spi_ch=current channel, then WAITC.
REQ-023 WAITC: on spi_done, store spi_data to the channel register, then SEND.
REQ-024 WAITC: if TIMEOUT cycles elapse without spi_done, store all-ones, set err_timeout, then SEND.
REQ-025 SEND emits the record 'C', '0'+ch, ':', then ceil(ADC_W/4) uppercase hex digits MSB first (the top nibble is zero-padded), then the terminator.
REQ-026 tx_load is pulsed only when tx_busy=0 and no tx_load occurred in the previous cycle; tx_data is held stable until the next load.
REQ-027 After the terminator: NEXT; ch<NUM_CH-1 → ch+1, CONV; else IDLE and scan_busy=0.
REQ-028 The period counter is free-running while auto_en=1, reloads at every period tick, and clears while auto_en=0.
REQ-029 A period tick while scan_busy=1 sets err_overrun and is remembered (one deep); the next scan starts in the cycle after return to IDLE.
REQ-030 A start pulse while scan_busy=1 is ignored and does not set any flag.
REQ-031 A start pulse coinciding with a period tick in IDLE starts exactly one scan.
REQ-032 A disp_sel value ≥ NUM_CH reads 0.
REQ-033 Sticky flags clear only on rst.

Reset
REQ-034 On rst=1, the block asynchronously sets: all outputs 0, tx_data=8'h00, all channel registers 0, counters 0, pending tick cleared, and state IDLE.
REQ-035 If rst asserts mid-scan or mid-record, the block emits no further bytes; after release it waits for a new trigger.

Configuration
REQ-036 Macro ADC_SCAN_CRLF_EN defined: the terminator is CR (8'h0D) then LF (8'h0A).
REQ-037 Macro ADC_SCAN_CRLF_EN undefined: the terminator is a single space (8'h20).

Structure
REQ-038 Package adc_scan_pkg holds the state enum, the ASCII constants ('C', ':', CR, LF, space, '0', 'A'), and the record-length constant.
REQ-039 Sub-module nibble_ascii: combinational 4-bit value → ASCII '0'-'9', 'A'-'F'; instantiated once.

Verification
REQ-040 NUM_CH=2, ADC_W=8, CRLF on; start; spi_data 8'h3A, then 8'hF0 → bytes "C0:3A\r\nC1:F0\r\n"; 14 loads.
REQ-041 ADC_W=10, spi_data 10'h2B7 → digits "2B7"; ADC_W=12, 12'h0C5 → "0C5".
REQ-042 spi_done withheld for TIMEOUT=64 → "C0:FF" sent, err_timeout=1, and the scan continues.
REQ-043 auto_en=1, PERIOD=200, scan length >200 cycles → err_overrun=1, and the next spi_start occurs 1 cycle after IDLE.
REQ-044 tx_busy held high 50 cycles after each load → no load while busy, none in back-to-back cycles, and the byte order is unchanged.
REQ-045 rst pulsed during the third byte → tx_load silent afterward, all outputs 0, and the next start gives a full clean record.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared types and constants for the ADC scan controller.
// Build option: ADC_SCAN_CRLF_EN selects a CR+LF record terminator;
// without it every record ends in a single space.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_WAITC = 3'd2,
        ST_SEND  = 3'd3,
        ST_NEXT  = 3'd4
    } state_t;

    localparam logic [7:0] ASC_C     = 8'h43;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;

    // Header is 'C', channel digit, ':'.
    localparam int HDR_LEN = 3;

`ifdef ADC_SCAN_CRLF_EN
    localparam int TERM_LEN = 2;
`else
    localparam int TERM_LEN = 1;
`endif

    // Hex digits needed to print an adc_w-bit sample.
    function automatic int hex_digits(input int adc_w);
        return (adc_w + 3) / 4;
    endfunction

    // Total bytes in one channel record.
    function automatic int rec_len(input int adc_w);
        return HDR_LEN + hex_digits(adc_w) + TERM_LEN;
    endfunction

endpackage

// File: rtl/adc_scan_ctrl_nibble_ascii.sv
// nibble_ascii: maps a 4-bit value to its uppercase ASCII hex character.
module nibble_ascii
    import adc_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] asc
);

    // Digits 0-9 map to '0'..'9', 10-15 map to 'A'..'F'.
    always_comb begin
        if (nib < 4'd10) begin
            asc = ASC_ZERO + {4'b0000, nib};
        end else begin
            asc = ASC_A + {4'b0000, nib} - 8'd10;
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scans NUM_CH ADC channels through an SPI master and
// prints each sample over a UART as "C<ch>:<hex><term>".
// Build option: ADC_SCAN_CRLF_EN makes the terminator CR+LF instead of ' '.
// tx handshake: a byte is loaded only when tx_busy is low and tx_load was
// low in the previous cycle; tx_data holds its value until the next load.
// dbg_state exposes the FSM state for external checkers.
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADC_W   = 8,
    parameter int PERIOD  = 1_000_000,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             auto_en,
    output logic             spi_start,
    output logic [2:0]       spi_ch,
    input  logic             spi_done,
    input  logic [ADC_W-1:0] spi_data,
    output logic [7:0]       tx_data,
    output logic             tx_load,
    input  logic             tx_busy,
    input  logic [2:0]       disp_sel,
    output logic [ADC_W-1:0] disp_data,
    output logic             scan_busy,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic [2:0]       dbg_state
);

    localparam int ND  = hex_digits(ADC_W);
    localparam int PW  = ND * 4;
    localparam int RL  = rec_len(ADC_W);
    localparam int PCW = $clog2(PERIOD);
    localparam int TCW = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       ch;
    logic [3:0]       idx;
    logic [PCW-1:0]   pcnt;
    logic [TCW-1:0]   tcnt;
    logic             pend;
    logic [ADC_W-1:0] ch_reg [0:7];

    logic             tick;
    logic             trigger;
    logic             can_load;
    logic             last_byte;
    logic             timed_out;
    logic             last_ch;
    logic [PW-1:0]    sample_pad;
    logic [3:0]       nib;
    logic [7:0]       hex_asc;
    logic [7:0]       cur_byte;

    assign tick      = auto_en && (pcnt == PCW'(PERIOD - 1));
    assign trigger   = start || tick || pend;
    assign can_load  = !tx_busy && !tx_load;
    assign last_byte = (idx == 4'(RL - 1));
    assign timed_out = (tcnt == TCW'(TIMEOUT - 1));
    assign last_ch   = (ch == 3'(NUM_CH - 1));

    nibble_ascii u_nibble_ascii (
        .nib (nib),
        .asc (hex_asc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_CONV;
            ST_CONV:  state_nxt = ST_WAITC;
            ST_WAITC: if (spi_done || timed_out) state_nxt = ST_SEND;
            ST_SEND:  if (can_load && last_byte) state_nxt = ST_NEXT;
            ST_NEXT:  state_nxt = last_ch ? ST_IDLE : ST_CONV;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        spi_start = (state == ST_CONV);
        scan_busy = (state != ST_IDLE);
        spi_ch    = ch;
        dbg_state = state;
    end

    // Select the record byte addressed by idx for the current channel.
    always_comb begin
        sample_pad = PW'(ch_reg[ch]);
        nib        = 4'h0;
        for (int k = 0; k < ND; k++) begin
            if (idx == 4'(HDR_LEN + k)) nib = sample_pad[(ND - 1 - k) * 4 +: 4];
        end
        if (idx == 4'd0) begin
            cur_byte = ASC_C;
        end else if (idx == 4'd1) begin
            cur_byte = ASC_ZERO + {5'b00000, ch};
        end else if (idx == 4'd2) begin
            cur_byte = ASC_COLON;
        end else if (idx < 4'(HDR_LEN + ND)) begin
            cur_byte = hex_asc;
        end else begin
`ifdef ADC_SCAN_CRLF_EN
            cur_byte = (idx == 4'(HDR_LEN + ND)) ? ASC_CR : ASC_LF;
`else
            cur_byte = ASC_SPACE;
`endif
        end
    end

    // Datapath: period counter, overrun memory, timeout, samples, tx bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch          <= 3'd0;
            idx         <= 4'd0;
            pcnt        <= '0;
            tcnt        <= '0;
            pend        <= 1'b0;
            tx_data     <= 8'h00;
            tx_load     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            for (int k = 0; k < 8; k++) ch_reg[k] <= '0;
        end else begin
            tx_load <= 1'b0;

            if (!auto_en || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end

            // A tick during a scan is remembered once; IDLE always consumes it.
            if (tick && state != ST_IDLE) begin
                err_overrun <= 1'b1;
                pend        <= 1'b1;
            end else if (state == ST_IDLE) begin
                pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (trigger) ch <= 3'd0;
                end
                ST_CONV: begin
                    tcnt <= '0;
                    idx  <= 4'd0;
                end
                ST_WAITC: begin
                    tcnt <= tcnt + 1'b1;
                    if (spi_done) begin
                        ch_reg[ch] <= spi_data;
                    end else if (timed_out) begin
                        ch_reg[ch]  <= '1;
                        err_timeout <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (can_load) begin
                        tx_load <= 1'b1;
                        tx_data <= cur_byte;
                        idx     <= idx + 4'd1;
                    end
                end
                ST_NEXT: begin
                    if (!last_ch) ch <= ch + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Combinational readback; out-of-range channels read zero.
    always_comb begin
        disp_data = '0;
        if ({1'b0, disp_sel} < 4'(NUM_CH)) disp_data = ch_reg[disp_sel];
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench for adc_scan_ctrl. A two-channel 8-bit
// instance carries most scenarios; two single-channel instances (10- and
// 12-bit samples) cover zero-padded hex output.
module tb_adc_scan_ctrl;

    localparam int NUM_CH  = 2;
    localparam int ADC_W   = 8;
    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic             start    = 1'b0;
    logic             auto_en  = 1'b0;
    logic             spi_done = 1'b0;
    logic [ADC_W-1:0] spi_data = '0;
    logic             tx_busy  = 1'b0;
    logic [2:0]       disp_sel = 3'd0;
    logic             spi_start;
    logic [2:0]       spi_ch;
    logic [7:0]       tx_data;
    logic             tx_load;
    logic [ADC_W-1:0] disp_data;
    logic             scan_busy;
    logic             err_timeout;
    logic             err_overrun;
    logic [2:0]       dbg_state;

    // ---------------- wide DUT signals ----------------
    logic        start_w    = 1'b0;
    logic        spi_done_w = 1'b0;
    logic [9:0]  spi_data_10 = '0;
    logic [11:0] spi_data_12 = '0;
    logic        spi_start_10, spi_start_12;
    logic [2:0]  spi_ch_10, spi_ch_12;
    logic [7:0]  tx_data_10, tx_data_12;
    logic        tx_load_10, tx_load_12;
    logic [9:0]  disp_data_10;
    logic [11:0] disp_data_12;
    logic        scan_busy_10, scan_busy_12;
    logic        err_timeout_10, err_timeout_12;
    logic        err_overrun_10, err_overrun_12;
    logic [2:0]  dbg_state_10, dbg_state_12;

    adc_scan_ctrl #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
        .spi_start(spi_start), .spi_ch(spi_ch), .spi_done(spi_done), .spi_data(spi_data),
        .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
        .disp_sel(disp_sel), .disp_data(disp_data), .scan_busy(scan_busy),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .dbg_state(dbg_state)
    );

    adc_scan_ctrl #(.NUM_CH(1), .ADC_W(10), .PERIOD(16), .TIMEOUT(TIMEOUT)) u_dut10 (
        .clk(clk), .rst(rst), .start(start_w), .auto_en(1'b0),
        .spi_start(spi_start_10), .spi_ch(spi_ch_10), .spi_done(spi_done_w), .spi_data(spi_data_10),
        .tx_data(tx_data_10), .tx_load(tx_load_10), .tx_busy(1'b0),
        .disp_sel(disp_sel), .disp_data(disp_data_10), .scan_busy(scan_busy_10),
        .err_timeout(err_timeout_10), .err_overrun(err_overrun_10), .dbg_state(dbg_state_10)
    );

    adc_scan_ctrl #(.NUM_CH(1), .ADC_W(12), .PERIOD(16), .TIMEOUT(TIMEOUT)) u_dut12 (
        .clk(clk), .rst(rst), .start(start_w), .auto_en(1'b0),
        .spi_start(spi_start_12), .spi_ch(spi_ch_12), .spi_done(spi_done_w), .spi_data(spi_data_12),
        .tx_data(tx_data_12), .tx_load(tx_load_12), .tx_busy(1'b0),
        .disp_sel(disp_sel), .disp_data(disp_data_12), .scan_busy(scan_busy_12),
        .err_timeout(err_timeout_12), .err_overrun(err_overrun_12), .dbg_state(dbg_state_12)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] cap10_q[$];
    logic [7:0] cap12_q[$];
    int         viol_b2b  = 0;
    int         viol_busy = 0;
    int         busy_len  = 0;
    int         busy_cnt  = 0;
    logic       prev_load = 1'b0;
    logic       prev_busy = 1'b0;

    // SPI responder programming.
    logic [7:0] spi_val [0:7];
    logic [7:0] drop_mask = 8'h00;
    int         rsp_cnt   = 0;
    logic [2:0] rsp_ch    = 3'd0;

    // UART model plus byte capture and handshake monitor, all at negedge.
    always @(negedge clk) begin
        if (tx_load) begin
            cap_q.push_back(tx_data);
            if (prev_load) viol_b2b++;
            if (prev_busy) viol_busy++;
        end
        prev_load = tx_load;
        if (busy_cnt != 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            tx_busy = 1'b0;
        end
        if (tx_load) busy_cnt = busy_len;
        prev_busy = tx_busy;
        if (tx_load_10) cap10_q.push_back(tx_data_10);
        if (tx_load_12) cap12_q.push_back(tx_data_12);
    end

    // SPI slave: answer a conversion request three cycles later unless dropped.
    always @(negedge clk) begin
        spi_done = 1'b0;
        if (rst) begin
            rsp_cnt = 0;
        end else if (spi_start) begin
            if (!drop_mask[spi_ch]) begin
                rsp_cnt = 3;
                rsp_ch  = spi_ch;
            end
        end else if (rsp_cnt != 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                spi_done = 1'b1;
                spi_data = spi_val[rsp_ch];
            end
        end
    end

    // Hard stop in case something never finishes.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helper tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_term();
`ifdef ADC_SCAN_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(8'h20);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic clear_caps();
        cap_q.delete();
        exp_q.delete();
        viol_b2b  = 0;
        viol_busy = 0;
    endtask

    // Wait until the main DUT has been idle for 8 consecutive cycles.
    task automatic wait_idle(input string tag);
        int n = 0;
        int quiet = 0;
        while (quiet < 8 && n < 6000) begin
            @(negedge clk);
            n++;
            if (!scan_busy) quiet++;
            else quiet = 0;
        end
        check(tag, {31'b0, (n < 6000)}, 32'd1);
    endtask

    task automatic check_disp(input string tag, input logic [2:0] sel, input logic [7:0] exp);
        @(negedge clk) disp_sel = sel;
        #1 check(tag, {24'h0, disp_data}, {24'h0, exp});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < 8; i++) spi_val[i] = 8'h00;

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        check("rst_spi_start", {31'b0, spi_start}, 32'd0);
        check("rst_spi_ch", {29'b0, spi_ch}, 32'd0);
        check("rst_tx_load", {31'b0, tx_load}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("rst_scan_busy", {31'b0, scan_busy}, 32'd0);
        check("rst_err_timeout", {31'b0, err_timeout}, 32'd0);
        check("rst_err_overrun", {31'b0, err_overrun}, 32'd0);
        check("rst_disp_data", {24'b0, disp_data}, 32'd0);
        check("rst_state", {29'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_trigger", {31'b0, scan_busy}, 32'd0);

        // Basic two-channel scan.
        busy_len = 2;
        spi_val[0] = 8'h3A;
        spi_val[1] = 8'hF0;
        clear_caps();
        push_str("C0:3A"); push_term(); push_str("C1:F0"); push_term();
        pulse_start();
        wait_idle("basic_done");
        check_bytes("basic", cap_q, exp_q);
        check("basic_b2b", viol_b2b, 0);
        check("basic_busy", viol_busy, 0);
        check_disp("disp_ch0", 3'd0, 8'h3A);
        check_disp("disp_ch1", 3'd1, 8'hF0);
        check_disp("disp_ch2_oor", 3'd2, 8'h00);
        check_disp("disp_ch7_oor", 3'd7, 8'h00);
        check("basic_err_to", {31'b0, err_timeout}, 32'd0);

        // Long UART busy after every load.
        busy_len = 50;
        spi_val[0] = 8'h5C;
        spi_val[1] = 8'h07;
        clear_caps();
        push_str("C0:5C"); push_term(); push_str("C1:07"); push_term();
        pulse_start();
        wait_idle("slow_done");
        check_bytes("slow", cap_q, exp_q);
        check("slow_b2b", viol_b2b, 0);
        check("slow_busy", viol_busy, 0);

        // Channel 0 never answers; a start during the scan is ignored.
        busy_len = 2;
        drop_mask = 8'h01;
        spi_val[1] = 8'h81;
        clear_caps();
        push_str("C0:FF"); push_term(); push_str("C1:81"); push_term();
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        wait_idle("timeout_done");
        check_bytes("timeout", cap_q, exp_q);
        check("timeout_err", {31'b0, err_timeout}, 32'd1);
        check("start_busy_no_overrun", {31'b0, err_overrun}, 32'd0);
        check_disp("timeout_disp", 3'd0, 8'hFF);
        drop_mask = 8'h00;

        // Periodic scanning slower than the period: overrun, then immediate restart.
        busy_len = 50;
        @(negedge clk) auto_en = 1'b1;
        n = 0;
        while (!scan_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("auto_started", {31'b0, scan_busy}, 32'd1);
        n = 0;
        while (scan_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("auto_scan_ended", {31'b0, scan_busy}, 32'd0);
        check("overrun_err", {31'b0, err_overrun}, 32'd1);
        @(negedge clk);
        check("overrun_restart", {31'b0, spi_start}, 32'd1);
        check("overrun_restart_ch", {29'b0, spi_ch}, 32'd0);
        auto_en = 1'b0;
        wait_idle("auto_done");
        check("sticky_timeout", {31'b0, err_timeout}, 32'd1);

        // Reset while the third byte of a record is pending.
        busy_len = 2;
        spi_val[0] = 8'h12;
        spi_val[1] = 8'h34;
        clear_caps();
        pulse_start();
        n = 0;
        while (cap_q.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midrec_two_bytes", cap_q.size(), 2);
        rst = 1'b1;
        #1;
        check("midrst_tx_load", {31'b0, tx_load}, 32'd0);
        check("midrst_tx_data", {24'b0, tx_data}, 32'd0);
        check("midrst_spi_start", {31'b0, spi_start}, 32'd0);
        check("midrst_scan_busy", {31'b0, scan_busy}, 32'd0);
        check("midrst_err_timeout", {31'b0, err_timeout}, 32'd0);
        check("midrst_err_overrun", {31'b0, err_overrun}, 32'd0);
        check("midrst_disp", {24'b0, disp_data}, 32'd0);
        check("midrst_state", {29'b0, dbg_state}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_silent", cap_q.size(), 2);
        check("midrst_stays_idle", {31'b0, scan_busy}, 32'd0);
        clear_caps();
        push_str("C0:12"); push_term(); push_str("C1:34"); push_term();
        pulse_start();
        wait_idle("post_rst_done");
        check_bytes("post_rst", cap_q, exp_q);

        // 10-bit and 12-bit samples.
        cap10_q.delete();
        cap12_q.delete();
        disp_sel = 3'd0;
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        n = 0;
        while (!spi_start_10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wide_spi_start", {31'b0, spi_start_10}, 32'd1);
        @(negedge clk);
        spi_done_w  = 1'b1;
        spi_data_10 = 10'h2B7;
        spi_data_12 = 12'h0C5;
        @(negedge clk) spi_done_w = 1'b0;
        n = 0;
        while ((scan_busy_10 || scan_busy_12) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("wide_done", {30'b0, scan_busy_10, scan_busy_12}, 32'd0);
        exp_q.delete();
        push_str("C0:2B7"); push_term();
        check_bytes("w10", cap10_q, exp_q);
        exp_q.delete();
        push_str("C0:0C5"); push_term();
        check_bytes("w12", cap12_q, exp_q);
        check("w10_disp", {22'b0, disp_data_10}, 32'h2B7);
        check("w12_disp", {20'b0, disp_data_12}, 32'h0C5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
